fht_rd_unload: RTL and testbench

Result unloader for the FHT core. After a transform completes, it drives the four bank read-address ports of the FHT RAM and captures the four bank data outputs. It undoes the bit-reversed row order and serialises the N = 4·2^A_BIT results as one natural-order sample stream with a valid/ready handshake. It sits between `fht_top` (oDATA_0..3, iADDR_RD_0..3) and any downstream consumer (DSP, UART/DMA bridge, test capture).

---
 rtl/fht_rd_unload_if.sv | 33 +++
 rtl/fht_rd_unload.sv | 189 ++++++++++++++++++
 tb/tb_fht_rd_unload.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_rd_unload_if.sv
// fht_rd_unload_if: FHT RAM read port plus the natural-order sample stream of the result unloader.
interface fht_rd_unload_if #(
    parameter int unsigned D_BIT = 16,
    parameter int unsigned A_BIT = 8
);
    logic             iSTART;
    logic [A_BIT-1:0] oADDR_RD_0;
    logic [A_BIT-1:0] oADDR_RD_1;
    logic [A_BIT-1:0] oADDR_RD_2;
    logic [A_BIT-1:0] oADDR_RD_3;
    logic [D_BIT-1:0] iDATA_0;
    logic [D_BIT-1:0] iDATA_1;
    logic [D_BIT-1:0] iDATA_2;
    logic [D_BIT-1:0] iDATA_3;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID;
    logic             iREADY;
    logic             oLAST;
    logic             oBUSY;
    logic             oDONE;

    modport master (
        input  iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oDATA, oVALID, oLAST, oBUSY, oDONE
    );

    modport slave (
        output iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oDATA, oVALID, oLAST, oBUSY, oDONE
    );
endinterface

// File: rtl/fht_rd_unload.sv
// fht_rd_unload: reads the four FHT RAM banks row by row and streams N = 4*2^A_BIT samples in natural order.
// Define FHT_RD_BITREV_EN for bit-reversed row addressing; otherwise rows are read linearly.
module fht_rd_unload #(
    parameter int unsigned D_BIT  = 16,
    parameter int unsigned A_BIT  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input logic             iCLK,
    input logic             iRESET,
    fht_rd_unload_if.master bus
);
    localparam int unsigned N_ROW = 1 << A_BIT;
    localparam int unsigned B_BIT = A_BIT + 2;
    localparam logic [B_BIT-1:0] LAST_BEAT = B_BIT'(4 * N_ROW - 1);
    localparam logic [A_BIT-1:0] LAST_ROW  = A_BIT'(N_ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    function automatic logic [A_BIT-1:0] row_addr(input logic [A_BIT-1:0] j);
        logic [A_BIT-1:0] r;
`ifdef FHT_RD_BITREV_EN
        for (int i = 0; i < int'(A_BIT); i++) r[i] = j[int'(A_BIT) - 1 - i];
`else
        r = j;
`endif
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [A_BIT-1:0] row_q, row_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic [RD_LAT:0]  pipe_q, pipe_d;
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       full_q, full_d;
    logic             rd_sel_q, rd_sel_d;
    logic             wr_sel_q, wr_sel_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [B_BIT-1:0] beat_q, beat_d;
    logic [D_BIT-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [D_BIT-1:0] rowbuf_q [2][4];
    logic [D_BIT-1:0] in_row [4];
    logic [D_BIT-1:0] word;
    logic             cap, avail, out_free, pop, free_buf, issue;

    assign in_row[0] = bus.iDATA_0;
    assign in_row[1] = bus.iDATA_1;
    assign in_row[2] = bus.iDATA_2;
    assign in_row[3] = bus.iDATA_3;

    // Next-state: fetcher, ping-pong capture, output streamer and control FSM.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        addr_d   = addr_q;
        occ_d    = occ_q;
        full_d   = full_q;
        rd_sel_d = rd_sel_q;
        wr_sel_d = wr_sel_q;
        bidx_d   = bidx_q;
        beat_d   = beat_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        issue    = 1'b0;

        cap      = pipe_q[RD_LAT];
        // An empty read buffer can only be the target of the row arriving now, so bypass it.
        avail    = full_q[rd_sel_q] | (cap & (wr_sel_q == rd_sel_q));
        word     = full_q[rd_sel_q] ? rowbuf_q[rd_sel_q][bidx_q] : in_row[bidx_q];
        out_free = ~valid_q | bus.iREADY;
        pop      = out_free & avail;
        free_buf = pop & (bidx_q == 2'd3);

        if (pop) begin
            data_d  = word;
            valid_d = 1'b1;
            last_d  = (beat_q == LAST_BEAT);
            beat_d  = (beat_q == LAST_BEAT) ? beat_q : beat_q + B_BIT'(1);
            bidx_d  = bidx_q + 2'd1;
            if (free_buf) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
        end else if (out_free) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (cap) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.iSTART && !done_q) begin
                    issue    = 1'b1;
                    row_d    = '0;
                    addr_d   = row_addr('0);
                    beat_d   = '0;
                    bidx_d   = '0;
                    rd_sel_d = 1'b0;
                    wr_sel_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (occ_q < 2'd2 || free_buf) begin
                    issue  = 1'b1;
                    row_d  = row_q + A_BIT'(1);
                    addr_d = row_addr(row_q + A_BIT'(1));
                    if (row_q + A_BIT'(1) == LAST_ROW) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (valid_q && last_q && bus.iREADY) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        occ_d  = occ_q + 2'(issue) - 2'(free_buf);
        pipe_d = {pipe_q[RD_LAT-1:0], issue};
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            addr_q   <= '0;
            pipe_q   <= '0;
            occ_q    <= '0;
            full_q   <= '0;
            rd_sel_q <= 1'b0;
            wr_sel_q <= 1'b0;
            bidx_q   <= '0;
            beat_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            pipe_q   <= pipe_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
            bidx_q   <= bidx_d;
            beat_q   <= beat_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Row payload storage; validity is tracked by full_q, so no reset is needed here.
    always_ff @(posedge iCLK) begin
        if (cap) begin
            for (int b = 0; b < 4; b++) rowbuf_q[wr_sel_q][b] <= in_row[b];
        end
    end

    assign bus.oADDR_RD_0 = addr_q;
    assign bus.oADDR_RD_1 = addr_q;
    assign bus.oADDR_RD_2 = addr_q;
    assign bus.oADDR_RD_3 = addr_q;
    assign bus.oDATA      = data_q;
    assign bus.oVALID     = valid_q;
    assign bus.oLAST      = last_q;
    assign bus.oBUSY      = busy_q;
    assign bus.oDONE      = done_q;
endmodule

// File: tb/tb_fht_rd_unload.sv
// tb_fht_rd_unload: directed bench for the FHT result unloader with a RAM model and a stream scoreboard.
`timescale 1ns/1ps
module tb_fht_rd_unload;
    localparam int D  = 16;
    localparam int A  = 8;
    localparam int L  = 3;
    localparam int NR = 1 << A;
    localparam int N  = 4 * NR;
`ifdef FHT_RD_BITREV_EN
    localparam int PIN_K4 = 4;
    localparam int PIN_R1 = 128;
`else
    localparam int PIN_K4 = 512;
    localparam int PIN_R1 = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fht_rd_unload_if #(.D_BIT(D), .A_BIT(A)) bus();
    fht_rd_unload #(.D_BIT(D), .A_BIT(A), .RD_LAT(L)) dut (
        .iCLK  (clk),
        .iRESET(rst),
        .bus   (bus)
    );

    // RAM model: data appears L cycles after the address is presented.
    logic [D-1:0] ram [4][NR];
    logic [A-1:0] addr_v [4];
    logic [A-1:0] ah [4][L];
    assign addr_v[0] = bus.oADDR_RD_0;
    assign addr_v[1] = bus.oADDR_RD_1;
    assign addr_v[2] = bus.oADDR_RD_2;
    assign addr_v[3] = bus.oADDR_RD_3;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            ah[b][0] <= addr_v[b];
            for (int i = 1; i < L; i++) ah[b][i] <= ah[b][i-1];
        end
    end
    assign bus.iDATA_0 = ram[0][ah[0][L-1]];
    assign bus.iDATA_1 = ram[1][ah[1][L-1]];
    assign bus.iDATA_2 = ram[2][ah[2][L-1]];
    assign bus.iDATA_3 = ram[3][ah[3][L-1]];

    // Consumer: 0 = always ready, 1 = random 50%, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       bus.iREADY = 1'($urandom_range(0, 1));
            2:       bus.iREADY = 1'b0;
            default: bus.iREADY = 1'b1;
        endcase
    end

    function automatic logic [A-1:0] brev(input logic [A-1:0] j);
        logic [A-1:0] r;
        for (int i = 0; i < A; i++) r[i] = j[A-1-i];
        return r;
    endfunction

    function automatic logic [A-1:0] rmap(input logic [A-1:0] j);
`ifdef FHT_RD_BITREV_EN
        return brev(j);
`else
        return j;
`endif
    endfunction

    // Sample k of the stream is bank k%4 at the RAM row that natural row k/4 maps to.
    function automatic logic [D-1:0] model_val(input int k);
        return ram[k % 4][rmap(A'(k / 4))];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream scoreboard, sampled on the falling edge.
    int           exp_k, first_vld_cyc, last_cyc, done_cyc, done_cnt;
    bit           stall_prev;
    logic [D-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            exp_k = 0; first_vld_cyc = -1; last_cyc = -1; done_cyc = -1;
            done_cnt = 0; stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", longint'(bus.oVALID), 1);
                chk("hold_data", longint'(bus.oDATA), longint'(prev_data));
            end
            if (bus.oVALID) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (exp_k >= N) chk("extra_beat", longint'(exp_k), longint'(N - 1));
                else begin
                    chk("data", longint'(bus.oDATA), longint'(model_val(exp_k)));
                    chk("last", longint'(bus.oLAST), longint'(exp_k == N - 1));
                end
                chk("busy_with_valid", longint'(bus.oBUSY), 1);
                if (bus.iREADY) begin
                    if (bus.oLAST) last_cyc = cyc;
                    exp_k++;
                end
            end
            if (bus.oDONE) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all", longint'(exp_k), longint'(N));
            end
            stall_prev = bus.oVALID && !bus.iREADY;
            prev_data  = bus.oDATA;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    task automatic start_run(output int t0);
        t0 = cyc;
        bus.iSTART = 1'b1;
        step(1);
        bus.iSTART = 1'b0;
    endtask

    task automatic wait_beat(input int k, input string nm);
        int n = 0;
        while (exp_k < k && n < 6000) begin @(negedge clk); #1; n++; end
        if (exp_k < k) chk(nm, longint'(exp_k), longint'(k));
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cnt == 0 && n < 8000) begin @(negedge clk); #1; n++; end
        chk(nm, longint'(done_cnt), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  longint'(bus.oADDR_RD_0), 0);
        chk({tag, "_data"},  longint'(bus.oDATA), 0);
        chk({tag, "_valid"}, longint'(bus.oVALID), 0);
        chk({tag, "_last"},  longint'(bus.oLAST), 0);
        chk({tag, "_busy"},  longint'(bus.oBUSY), 0);
        chk({tag, "_done"},  longint'(bus.oDONE), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        logic [A-1:0] a5;
        bus.iSTART = 1'b0;
        for (int j = 0; j < NR; j++)
            for (int b = 0; b < 4; b++) ram[b][brev(A'(j))] = D'(4 * j + b);
        chk("model_pin_k4", longint'(model_val(4)), PIN_K4);
        chk("model_pin_k1023", longint'(model_val(N - 1)), 1023);

        // Reset state
        step(2);
        chk_reset_outputs("rst");
        rst = 1'b0;
        step(2);

        // Run A: full-rate readout, stray iSTART at beat 100 and in the oDONE cycle
        rdy_mode = 0;
        start_run(t0);
        chk("addr_row0", longint'(bus.oADDR_RD_0), 0);
        chk("busy_after_start", longint'(bus.oBUSY), 1);
        step(1);
        chk("addr_row1", longint'(bus.oADDR_RD_0), PIN_R1);
        chk("addr_bank1_eq", longint'(bus.oADDR_RD_1), PIN_R1);
        chk("addr_bank2_eq", longint'(bus.oADDR_RD_2), PIN_R1);
        chk("addr_bank3_eq", longint'(bus.oADDR_RD_3), PIN_R1);
        wait_beat(100, "reach_beat100");
        bus.iSTART = 1'b1;
        step(1);
        bus.iSTART = 1'b0;
        n = 0;
        while (!bus.oDONE && n < 4000) begin @(negedge clk); #1; n++; end
        chk("runA_done_seen", longint'(bus.oDONE), 1);
        bus.iSTART = 1'b1;
        step(1);
        bus.iSTART = 1'b0;
        chk("start_in_done_ignored", longint'(bus.oBUSY), 0);
        step(10);
        chk("runA_first_valid_lat", longint'(first_vld_cyc - t0), 5);
        chk("runA_last_lat", longint'(last_cyc - t0), 1028);
        chk("runA_done_lat", longint'(done_cyc - t0), 1029);
        chk("runA_beats", longint'(exp_k), N);
        chk("runA_one_done", longint'(done_cnt), 1);
        chk("runA_idle_valid", longint'(bus.oVALID), 0);

        // Run B: random backpressure
        do_reset();
        rdy_mode = 1;
        start_run(t0);
        wait_done("runB_done");
        chk("runB_beats", longint'(exp_k), N);
        step(5);
        chk("runB_one_done", longint'(done_cnt), 1);

        // Run C: consumer stalled for 20 cycles from the first oVALID
        rdy_mode = 2;
        do_reset();
        start_run(t0);
        n = 0;
        while (!bus.oVALID && n < 100) begin @(negedge clk); #1; n++; end
        chk("runC_first_valid", longint'(bus.oVALID), 1);
        step(5);
        a5 = bus.oADDR_RD_0;
        step(14);
        chk("runC_addr_held", longint'(bus.oADDR_RD_0), longint'(a5));
        chk("runC_addr_row1", longint'(bus.oADDR_RD_0), PIN_R1);
        chk("runC_data_held", longint'(bus.oDATA), 0);
        chk("runC_beats_stalled", longint'(exp_k), 0);
        rdy_mode = 0;
        wait_done("runC_done");
        chk("runC_beats", longint'(exp_k), N);

        // Run D: asynchronous reset at beat 500, then a fresh full run
        do_reset();
        start_run(t0);
        wait_beat(500, "reach_beat500");
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        step(2);
        rst = 1'b0;
        step(1);
        chk("midrst_no_done", longint'(done_cnt), 0);
        start_run(t0);
        chk("runD_addr_row0", longint'(bus.oADDR_RD_0), 0);
        wait_done("runD_done");
        chk("runD_beats", longint'(exp_k), N);
        chk("runD_first_valid_lat", longint'(first_vld_cyc - t0), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
